// File: rtl/gbar_responder.sv
// Global-barrier responder. It counts arrivals per barrier ID and broadcasts a
// one-cycle release pulse when the last expected core arrives.

module gbar_slot #(
    parameter int NUM_CORES = 4,
    parameter int NC_WIDTH  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hit,
    input  logic [NC_WIDTH-1:0] size_m1,
    input  logic [NC_WIDTH-1:0] core_id,
    output logic                rel,
    output logic                err,
    output logic                active
);
    logic [NUM_CORES-1:0] mask;
    logic [NUM_CORES-1:0] core_bit;
    logic [NC_WIDTH:0]    cnt;
    logic [NC_WIDTH-1:0]  size;
    logic                 dup;
    logic                 last;

    assign core_bit = NUM_CORES'(1) << core_id;
    assign active   = (cnt != '0);
    assign dup      = active && |(mask & core_bit);
    // The latched size is authoritative; a mismatching request is only flagged.
    assign last     = active && !dup && (cnt == {1'b0, size});
    assign rel      = hit && (active ? last : (size_m1 == '0));
    assign err      = hit && active && (dup || (size_m1 != size));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask <= '0;
            cnt  <= '0;
            size <= '0;
        end else if (hit) begin
            if (!active) begin
                if (size_m1 != '0) begin
                    size <= size_m1;
                    mask <= core_bit;
                    cnt  <= (NC_WIDTH+1)'(1);
                end
            end else if (!dup) begin
                if (last) begin
                    mask <= '0;
                    cnt  <= '0;
                end else begin
                    mask <= mask | core_bit;
                    cnt  <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

module gbar_responder #(
    parameter int NUM_BARRIERS = 4,
    parameter int NUM_CORES    = 4,
    parameter int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
    parameter int NC_WIDTH     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic [NB_WIDTH-1:0] req_id,
    input  logic [NC_WIDTH-1:0] req_size_m1,
    input  logic [NC_WIDTH-1:0] req_core_id,
    output logic                req_ready,
    output logic                rsp_valid,
    output logic [NB_WIDTH-1:0] rsp_id,
    output logic                busy,
    output logic                err_dup
);
    logic                    accept;
    logic [NUM_BARRIERS-1:0] hit;
    logic [NUM_BARRIERS-1:0] rel;
    logic [NUM_BARRIERS-1:0] err;
    logic [NUM_BARRIERS-1:0] act;

    assign accept = req_valid && req_ready;

    for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_slot
        assign hit[b] = accept && (req_id == NB_WIDTH'(b));
        gbar_slot #(
            .NUM_CORES (NUM_CORES),
            .NC_WIDTH  (NC_WIDTH)
        ) u_slot (
            .clk     (clk),
            .reset   (reset),
            .hit     (hit[b]),
            .size_m1 (req_size_m1),
            .core_id (req_core_id),
            .rel     (rel[b]),
            .err     (err[b]),
            .active  (act[b])
        );
    end

    // An accepted request that hits no slot carries an out-of-range ID.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            busy      <= 1'b0;
            err_dup   <= 1'b0;
        end else begin
            req_ready <= 1'b1;
            rsp_valid <= |rel;
            if (|rel) rsp_id <= req_id;
            busy      <= |act;
            if (accept && (~|hit || |err)) err_dup <= 1'b1;
        end
    end
endmodule

// File: tb/tb_gbar_responder.sv
// Directed bench for gbar_responder: per-cycle vector table plus hand-written
// reset and size-mismatch sequences.

module tb_gbar_responder;
    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_id;
    logic [1:0] req_size_m1;
    logic [1:0] req_core_id;
    logic       req_ready;
    logic       rsp_valid;
    logic [1:0] rsp_id;
    logic       busy;
    logic       err_dup;

    int n_cmp = 0;
    int n_bad = 0;

    gbar_responder dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_id      (req_id),
        .req_size_m1 (req_size_m1),
        .req_core_id (req_core_id),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .busy        (busy),
        .err_dup     (err_dup)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] id;
        logic [1:0] sz;
        logic [1:0] c;
        logic       rv;
        logic [1:0] rid;
        logic       bz;
        logic       er;
    } vec_t;

    vec_t vt[22];

    function automatic vec_t mk(logic v, int id, int sz, int c, logic rv, int rid, logic bz, logic er);
        vec_t t;
        t.v = v; t.id = 2'(id); t.sz = 2'(sz); t.c = 2'(c);
        t.rv = rv; t.rid = 2'(rid); t.bz = bz; t.er = er;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic v, int id, int sz, int c);
        req_valid   = v;
        req_id      = 2'(id);
        req_size_m1 = 2'(sz);
        req_core_id = 2'(c);
    endtask

    // Apply one request, clock it in, and check outputs just after the edge.
    task automatic step(string tag, logic v, int id, int sz, int c, logic rv, int rid, logic bz, logic er);
        drive(v, id, sz, c);
        @(posedge clk); #1;
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(rv));
        if (rv) chk({tag, ".rsp_id"}, 32'(rsp_id), 32'(rid));
        chk({tag, ".busy"}, 32'(busy), 32'(bz));
        chk({tag, ".err_dup"}, 32'(err_dup), 32'(er));
    endtask

    initial begin
        // 4 cores on id 2 in order 3,0,2,1
        vt[0]  = mk(1, 2, 3, 3, 0, 0, 0, 0);
        vt[1]  = mk(1, 2, 3, 0, 0, 0, 1, 0);
        vt[2]  = mk(1, 2, 3, 2, 0, 0, 1, 0);
        vt[3]  = mk(1, 2, 3, 1, 1, 2, 1, 0);
        vt[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
        // single-core barrier
        vt[5]  = mk(1, 1, 0, 0, 1, 1, 0, 0);
        vt[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
        // interleaved id 0 (cores 0,1) and id 3 (cores 1,2,3)
        vt[7]  = mk(1, 0, 1, 0, 0, 0, 0, 0);
        vt[8]  = mk(1, 3, 2, 1, 0, 0, 1, 0);
        vt[9]  = mk(1, 0, 1, 1, 1, 0, 1, 0);
        vt[10] = mk(1, 3, 2, 2, 0, 0, 1, 0);
        vt[11] = mk(1, 3, 2, 3, 1, 3, 1, 0);
        vt[12] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        // duplicate core 2 on id 0
        vt[13] = mk(1, 0, 1, 2, 0, 0, 0, 0);
        vt[14] = mk(1, 0, 1, 2, 0, 0, 1, 1);
        vt[15] = mk(1, 0, 1, 0, 1, 0, 1, 1);
        vt[16] = mk(0, 0, 0, 0, 0, 0, 0, 1);
        // back-to-back reuse of id 1, re-arrival during the release pulse
        vt[17] = mk(1, 1, 1, 0, 0, 0, 0, 1);
        vt[18] = mk(1, 1, 1, 1, 1, 1, 1, 1);
        vt[19] = mk(1, 1, 1, 0, 0, 0, 0, 1);
        vt[20] = mk(1, 1, 1, 1, 1, 1, 1, 1);
        vt[21] = mk(0, 0, 0, 0, 0, 0, 0, 1);

        reset = 1'b0;
        drive(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rst%0d.req_ready", i), 32'(req_ready), 0);
            chk($sformatf("rst%0d.rsp_valid", i), 32'(rsp_valid), 0);
            chk($sformatf("rst%0d.busy", i), 32'(busy), 0);
            chk($sformatf("rst%0d.err_dup", i), 32'(err_dup), 0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst.req_ready", 32'(req_ready), 1);

        for (int i = 0; i < 22; i++)
            step($sformatf("v%0d", i), vt[i].v, vt[i].id, vt[i].sz, vt[i].c,
                 vt[i].rv, vt[i].rid, vt[i].bz, vt[i].er);

        // Reset after 2 of 4 arrivals discards them.
        step("mr0", 1, 2, 3, 0, 0, 0, 0, 1);
        step("mr1", 1, 2, 3, 1, 0, 0, 1, 1);
        drive(0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("mr_async.req_ready", 32'(req_ready), 0);
        chk("mr_async.busy", 32'(busy), 0);
        chk("mr_async.err_dup", 32'(err_dup), 0);
        chk("mr_async.rsp_valid", 32'(rsp_valid), 0);
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mr_rel.req_ready", 32'(req_ready), 1);
        chk("mr_rel.rsp_valid", 32'(rsp_valid), 0);
        step("mf0", 1, 2, 3, 2, 0, 0, 0, 0);
        step("mf1", 1, 2, 3, 3, 0, 0, 1, 0);
        step("mf2", 1, 2, 3, 0, 0, 0, 1, 0);
        step("mf3", 1, 2, 3, 1, 1, 2, 1, 0);
        step("mf4", 0, 0, 0, 0, 0, 0, 0, 0);

        // Size mismatch: counted against the latched size of 3 cores.
        step("sm0", 1, 3, 2, 0, 0, 0, 0, 0);
        step("sm1", 1, 3, 1, 1, 0, 0, 1, 1);
        step("sm2", 1, 3, 2, 2, 1, 3, 1, 1);
        step("sm3", 0, 0, 0, 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gbar_responder.md
Name: gbar_responder

Overview:
- Cluster-level responder for the global-barrier request/response interface that each core drives through its gbar_req_*/gbar_rsp_* ports.
- Collects arrivals per barrier ID from up to NUM_CORES cores.
- When the last expected core arrives, broadcasts a one-cycle release (rsp_valid + rsp_id) to all cores and recycles the barrier.
- Sits between the core tops and the cluster; one instance per cluster.

Parameters:
- NUM_BARRIERS, 4, number of barrier IDs tracked.
- NUM_CORES, 4, number of participating cores.
- NB_WIDTH, max(1,$clog2(NUM_BARRIERS)), barrier ID width.
- NC_WIDTH, max(1,$clog2(NUM_CORES)), core ID / size width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  1  barrier arrival request.
- req_id  in  NB_WIDTH  barrier ID.
- req_size_m1  in  NC_WIDTH  participating cores minus one.
- req_core_id  in  NC_WIDTH  arriving core.
- req_ready  out  1  request accepted when req_valid & req_ready.
- rsp_valid  out  1  release pulse, broadcast, no back-pressure.
- rsp_id  out  NB_WIDTH  released barrier ID.
- busy  out  1  any barrier has at least one pending arrival.
- err_dup  out  1  sticky flag: duplicate arrival or size mismatch seen.

Behaviour:
- Reset (reset==0, async): all per-barrier state cleared; req_ready=0, rsp_valid=0, rsp_id=0, busy=0, err_dup=0.
- req_ready is a flop: 0 during reset, 1 from the first clk edge after reset deasserts, then stays 1. Requests are never stalled.
- Per-barrier state, for each b in 0..NUM_BARRIERS-1:
  - mask[b]: NUM_CORES bits.
  - cnt[b]: NC_WIDTH+1 bits.
  - size[b]: NC_WIDTH bits, latched from the first arrival.
  - Barrier states: IDLE (cnt==0) and ACTIVE (cnt>0).
- Accepted request (valid & ready) for barrier b = req_id, core c:
  - IDLE, req_size_m1==0: release immediately; barrier stays IDLE.
  - IDLE, req_size_m1>0: size[b]=req_size_m1, mask[b]={c}, cnt=1; go ACTIVE.
  - ACTIVE, mask[b][c] already set: arrival ignored (no count change); err_dup set.
  - ACTIVE, req_size_m1 != size[b]: arrival counted normally, compared against latched size[b]; err_dup set.
  - ACTIVE, new core, cnt[b]==size[b]: release; mask[b] and cnt[b] cleared; go IDLE.
  - ACTIVE, new core, otherwise: set mask bit, cnt+1.
- Release timing: rsp_valid=1 and rsp_id=b are registered and appear the cycle after the completing request is accepted. rsp_valid is a single-cycle pulse. At most one release per cycle because at most one request is accepted per cycle.
- A request accepted in the same cycle a release pulse is output is processed normally. A new arrival for the just-released ID starts a fresh barrier instance.
- req_id >= NUM_BARRIERS (non-power-of-two case): request accepted and dropped; err_dup set.
- busy is registered: OR of (cnt[b]!=0), updated one cycle after state changes.
- err_dup clears only on reset.
- Reset mid-operation: all partial arrivals are discarded and no release is issued.

Test Plan:
- Reset hold 3 cycles then release -> during reset req_ready=0, rsp_valid=0, busy=0; req_ready=1 on the first edge after release.
- 4 cores arrive on id=2, size_m1=3, one per cycle in core order 3,0,2,1 -> no rsp after the first 3 arrivals (busy=1); rsp_valid=1, rsp_id=2 exactly one cycle after the 4th; busy=0 the following cycle.
- Single core, id=1, size_m1=0 -> rsp_valid=1, rsp_id=1 the next cycle; busy stays 0.
- Interleaved: id=0 with size_m1=1 (cores 0,1) and id=3 with size_m1=2 (cores 1,2,3), alternating arrivals -> id=0 releases after core 1's arrival, id=3 after core 3's arrival; each pulse is one cycle; no cross-talk between IDs.
- Duplicate: core 2 arrives twice on id=0 with size_m1=1 -> no release, err_dup=1; core 0 then arrives -> release id=0; err_dup remains 1.
- Back-to-back reuse: id=1 with size_m1=1 completes, and core 0 arrives on id=1 in the release-pulse cycle -> new instance with cnt=1 and no second pulse; core 1 then arrives -> second release of id=1.
- Reset asserted after 2 of 4 arrivals -> state cleared; after reset, 4 fresh arrivals are required for a release.
